// File: rtl/lisnoc_dma_request_scheduler_if.sv
// Request-table / initiator signal bundle for the DMA request scheduler (sched_timeout only with LISNOC_DMA_SCHED_TIMEOUT_EN).
// Latency: none, wires only.
// Backpressure: req_start/req_ack handshake; req_cmpl closes a transfer; done_set writes back to the table.
interface lisnoc_dma_request_scheduler_if #(
   parameter int table_entries = 4
);
   logic [table_entries-1:0] valid;
   logic [table_entries-1:0] done;
   logic [1:0]               req_pos;
   logic                     req_start;
   logic                     req_ack;
   logic                     req_cmpl;
   logic                     done_set;
   logic [1:0]               done_pos;
   logic                     busy;
`ifdef LISNOC_DMA_SCHED_TIMEOUT_EN
   logic                     sched_timeout;
`endif

   // Scheduler side
   modport master (
      input  valid, done, req_ack, req_cmpl,
      output req_pos, req_start, done_set, done_pos, busy
`ifdef LISNOC_DMA_SCHED_TIMEOUT_EN
      , output sched_timeout
`endif
   );

   // Request table / initiator side
   modport slave (
      output valid, done, req_ack, req_cmpl,
      input  req_pos, req_start, done_set, done_pos, busy
`ifdef LISNOC_DMA_SCHED_TIMEOUT_EN
      , input sched_timeout
`endif
   );
endinterface

// File: rtl/lisnoc_dma_request_scheduler.sv
// Round-robin DMA request scheduler: grants one valid, not-done entry at a time to the initiator; LISNOC_DMA_SCHED_TIMEOUT_EN adds a WAIT timeout.
// Latency: grant registered one cycle after eligibility; done_set one cycle after completion; next scan two cycles after FINISH.
// Backpressure: req_start held until req_ack; single transfer outstanding; WAIT holds until req_cmpl (or timeout when enabled).
module lisnoc_dma_request_scheduler #(
   parameter int table_entries = 4,
   parameter int tileid = 0
`ifdef LISNOC_DMA_SCHED_TIMEOUT_EN
   ,
   parameter int timeout_cycles = 1024
`endif
) (
   input logic clk,
   input logic rst,
   lisnoc_dma_request_scheduler_if.master bus
);
   localparam int PTR_W = 2;
   localparam int SLOTS = 1 << PTR_W;

   // tileid only tags the trace; it is checked here so a bad build fails early.
   if (table_entries < 1 || table_entries > SLOTS || tileid < 0) begin : g_bad_params
      $error("lisnoc_dma_request_scheduler: table_entries must be 1..4 and tileid non-negative");
   end

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISSUE  = 2'd1,
      WAIT   = 2'd2,
      FINISH = 2'd3
   } state_t;

   state_t           state;
   logic [PTR_W-1:0] rr_last;
   logic [PTR_W-1:0] req_pos_q;
   logic             req_start_q;
   logic             done_set_q;
   logic [PTR_W-1:0] done_pos_q;
   logic             busy_q;

   // Table bits padded to the pointer range so any pointer value indexes safely.
   logic [SLOTS-1:0] valid_pad;
   logic [SLOTS-1:0] elig_pad;
   logic [PTR_W-1:0] winner;
   logic [PTR_W-1:0] cand;
   logic             found;

   assign valid_pad = SLOTS'(bus.valid);
   assign elig_pad  = SLOTS'(bus.valid & ~bus.done);

   // Round-robin pick: first eligible entry after rr_last, wrapping modulo table_entries.
   always_comb begin
      winner = '0;
      cand   = '0;
      found  = 1'b0;
      for (int i = 1; i <= table_entries; i++) begin
         cand = PTR_W'((int'(rr_last) + i) % table_entries);
         if (!found && elig_pad[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
   end

`ifdef LISNOC_DMA_SCHED_TIMEOUT_EN
   localparam int CNT_W = (timeout_cycles > 2) ? $clog2(timeout_cycles) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(timeout_cycles - 1);

   logic [CNT_W-1:0] wait_cnt;
   logic             timeout_hit;

   // Last WAIT cycle with no completion. Gated by req_cmpl in the same cycle so
   // a late completion wins and the timeout pulse is suppressed.
   assign timeout_hit       = (state == WAIT) && (wait_cnt == CNT_LAST) && !bus.req_cmpl;
   assign bus.sched_timeout = timeout_hit;
`endif

   // Scheduler FSM with registered handshake and write-back outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= IDLE;
         rr_last     <= PTR_W'(table_entries - 1);
         req_pos_q   <= '0;
         req_start_q <= 1'b0;
         done_set_q  <= 1'b0;
         done_pos_q  <= '0;
         busy_q      <= 1'b0;
`ifdef LISNOC_DMA_SCHED_TIMEOUT_EN
         wait_cnt    <= '0;
`endif
      end else begin
         done_set_q <= 1'b0;
         case (state)
            IDLE: begin
               if (found) begin
                  req_pos_q   <= winner;
                  req_start_q <= 1'b1;
                  busy_q      <= 1'b1;
                  state       <= ISSUE;
               end
            end
            ISSUE: begin
               // Ack takes priority over a simultaneous withdrawal.
               if (bus.req_ack) begin
                  rr_last     <= req_pos_q;
                  req_start_q <= 1'b0;
                  if (bus.req_cmpl) begin
                     done_set_q <= 1'b1;
                     done_pos_q <= req_pos_q;
                     state      <= FINISH;
                  end else begin
                     state      <= WAIT;
`ifdef LISNOC_DMA_SCHED_TIMEOUT_EN
                     wait_cnt   <= '0;
`endif
                  end
               end else if (!valid_pad[req_pos_q]) begin
                  req_start_q <= 1'b0;
                  busy_q      <= 1'b0;
                  state       <= IDLE;
               end
            end
            WAIT: begin
               // Table changes are ignored here; the transfer always completes.
               if (bus.req_cmpl) begin
                  done_set_q <= 1'b1;
                  done_pos_q <= req_pos_q;
                  state      <= FINISH;
`ifdef LISNOC_DMA_SCHED_TIMEOUT_EN
               end else if (timeout_hit) begin
                  done_set_q <= 1'b1;
                  done_pos_q <= req_pos_q;
                  state      <= FINISH;
               end else begin
                  wait_cnt   <= wait_cnt + 1'b1;
`endif
               end
            end
            FINISH: begin
               // One IDLE cycle follows so the table's done update lands before the next scan.
               busy_q <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               req_start_q <= 1'b0;
               busy_q      <= 1'b0;
               state       <= IDLE;
            end
         endcase
      end
   end

   assign bus.req_pos   = req_pos_q;
   assign bus.req_start = req_start_q;
   assign bus.done_set  = done_set_q;
   assign bus.done_pos  = done_pos_q;
   assign bus.busy      = busy_q;
endmodule

// File: tb/tb_lisnoc_dma_request_scheduler.sv
// Bench for the DMA request scheduler: constant vectors, directed corner sequences and a random run against a transaction model.
// Latency: inputs driven on the falling edge, outputs sampled on the following falling edge.
// Backpressure: the bench plays both request table (sets done on done_set) and initiator (ack/cmpl).
module tb_lisnoc_dma_request_scheduler;
   localparam int N      = 4;
   localparam int TO_CYC = 8;
   localparam int P_IDLE = 0, P_ISSUE = 1, P_WAIT = 2, P_FIN = 3;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   lisnoc_dma_request_scheduler_if #(.table_entries(N)) bus();

   lisnoc_dma_request_scheduler #(
      .table_entries(N),
      .tileid(0)
`ifdef LISNOC_DMA_SCHED_TIMEOUT_EN
      ,
      .timeout_cycles(TO_CYC)
`endif
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   logic [N-1:0] valid_r;
   logic [N-1:0] done_r;
   logic         to_seen;

   // Transaction-level model: what phase the transfer is in, which entry, last grant.
   int m_phase, m_rr, m_pos, m_wcnt;

   typedef struct {
      logic [N-1:0] valid;
      logic [N-1:0] done;
      logic         exp_start;
      int           exp_pos;
   } vec_t;
   vec_t vecs[8];

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // First eligible entry strictly after 'last', wrapping; -1 when none.
   function automatic int rr_pick(input int last, input logic [N-1:0] e);
      for (int i = 1; i <= N; i++) begin
         if (e[(last + i) % N]) return (last + i) % N;
      end
      return -1;
   endfunction

   task automatic model_advance(input logic a, input logic c);
      logic [N-1:0] e;
      e = valid_r & ~done_r;
      case (m_phase)
         P_IDLE: if (e != '0) begin
            m_pos   = rr_pick(m_rr, e);
            m_phase = P_ISSUE;
         end
         P_ISSUE: if (a) begin
            m_rr    = m_pos;
            m_wcnt  = 1;
            m_phase = c ? P_FIN : P_WAIT;
         end else if (!valid_r[m_pos]) begin
            m_phase = P_IDLE;
         end
         P_WAIT: begin
            if (c) m_phase = P_FIN;
`ifdef LISNOC_DMA_SCHED_TIMEOUT_EN
            else if (m_wcnt == TO_CYC) m_phase = P_FIN;
`endif
            else m_wcnt++;
         end
         default: m_phase = P_IDLE;
      endcase
   endtask

   task automatic model_check();
      chk("req_start", int'(bus.req_start), int'(m_phase == P_ISSUE));
      chk("busy", int'(bus.busy), int'(m_phase != P_IDLE));
      chk("done_set", int'(bus.done_set), int'(m_phase == P_FIN));
      if (m_phase == P_ISSUE) chk("req_pos", int'(bus.req_pos), m_pos);
      if (m_phase == P_FIN)   chk("done_pos", int'(bus.done_pos), m_pos);
   endtask

   // One clock: drive table and initiator, step the model, sample on the next falling edge.
   task automatic tick(input logic a, input logic c);
      bus.valid    = valid_r;
      bus.done     = done_r;
      bus.req_ack  = a;
      bus.req_cmpl = c;
      to_seen      = 1'b0;
`ifdef LISNOC_DMA_SCHED_TIMEOUT_EN
      #1;
      to_seen = bus.sched_timeout;
      chk("sched_timeout", int'(to_seen), int'(m_phase == P_WAIT && m_wcnt == TO_CYC && !c));
`endif
      model_advance(a, c);
      @(negedge clk);
      model_check();
      if (bus.done_set) done_r[bus.done_pos] = 1'b1;
   endtask

   task automatic do_reset(input int n);
      rst          = 1'b0;
      bus.valid    = valid_r;
      bus.done     = done_r;
      bus.req_ack  = 1'b0;
      bus.req_cmpl = 1'b0;
      m_phase = P_IDLE;
      m_rr    = N - 1;
      m_pos   = 0;
      m_wcnt  = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk("rst_req_start", int'(bus.req_start), 0);
         chk("rst_busy", int'(bus.busy), 0);
         chk("rst_done_set", int'(bus.done_set), 0);
         chk("rst_req_pos", int'(bus.req_pos), 0);
         chk("rst_done_pos", int'(bus.done_pos), 0);
      end
      rst = 1'b1;
   endtask

   initial begin
      vecs[0] = '{4'b1111, 4'b0000, 1'b1, 0};
      vecs[1] = '{4'b1010, 4'b0000, 1'b1, 1};
      vecs[2] = '{4'b1000, 4'b0000, 1'b1, 3};
      vecs[3] = '{4'b1111, 4'b1111, 1'b0, 0};
      vecs[4] = '{4'b0110, 4'b0010, 1'b1, 2};
      vecs[5] = '{4'b0000, 4'b0000, 1'b0, 0};
      vecs[6] = '{4'b1100, 4'b0100, 1'b1, 3};
      vecs[7] = '{4'b0101, 4'b0001, 1'b1, 2};

      // Reset held with every entry eligible, then grant of entry 0.
      valid_r = 4'b1111;
      done_r  = 4'b0000;
      do_reset(3);
      tick(0, 0);
      chk("post_rst_start", int'(bus.req_start), 1);
      chk("post_rst_pos", int'(bus.req_pos), 0);

      // Round-robin over a full table: ack after 1 cycle, complete 2 cycles later.
      for (int k = 0; k < N; k++) begin
         chk($sformatf("rr%0d_start", k), int'(bus.req_start), 1);
         chk($sformatf("rr%0d_pos", k), int'(bus.req_pos), k);
         tick(0, 0);
         tick(1, 0);
         tick(0, 0);
         tick(0, 1);
         chk($sformatf("rr%0d_done_set", k), int'(bus.done_set), 1);
         chk($sformatf("rr%0d_done_pos", k), int'(bus.done_pos), k);
         tick(0, 0);
         tick(0, 0);
      end
      chk("rr_exhausted_start", int'(bus.req_start), 0);
      tick(0, 0);
      chk("rr_exhausted_busy", int'(bus.busy), 0);

      // Skip and wrap: park rr_last on 2, then 1010 grants 3 then 1.
      valid_r = 4'b0100;
      done_r  = 4'b0000;
      tick(0, 0);
      chk("park_pos", int'(bus.req_pos), 2);
      tick(1, 1);
      tick(0, 0);
      valid_r = 4'b1010;
      done_r  = 4'b0000;
      tick(0, 0);
      chk("wrap_first_pos", int'(bus.req_pos), 3);
      tick(1, 1);
      tick(0, 0);
      tick(0, 0);
      chk("wrap_second_start", int'(bus.req_start), 1);
      chk("wrap_second_pos", int'(bus.req_pos), 1);
      tick(1, 1);
      tick(0, 0);

      // Withdraw entry 2 before ack; rr_last stays on 1 so entry 2 wins again.
      valid_r = 4'b0100;
      done_r  = 4'b0000;
      tick(0, 0);
      chk("wd_grant_pos", int'(bus.req_pos), 2);
      tick(0, 0);
      valid_r[2] = 1'b0;
      tick(0, 0);
      chk("wd_start", int'(bus.req_start), 0);
      chk("wd_busy", int'(bus.busy), 0);
      chk("wd_done_set", int'(bus.done_set), 0);
      tick(0, 0);
      chk("wd_done_set_later", int'(bus.done_set), 0);
      valid_r = 4'b1111;
      tick(0, 0);
      chk("wd_regrant_start", int'(bus.req_start), 1);
      chk("wd_regrant_pos", int'(bus.req_pos), 2);
      tick(1, 1);
      tick(0, 0);

      // Ack and completion in the same cycle on entry 1.
      valid_r = 4'b0010;
      done_r  = 4'b0000;
      do_reset(2);
      tick(0, 0);
      chk("same_grant_pos", int'(bus.req_pos), 1);
      tick(1, 1);
      chk("same_done_set", int'(bus.done_set), 1);
      chk("same_done_pos", int'(bus.done_pos), 1);
      tick(0, 0);
      chk("same_done_set_once", int'(bus.done_set), 0);
      chk("same_idle", int'(bus.busy), 0);

      // First grant from reset for a set of table images.
      for (int v = 0; v < 8; v++) begin
         valid_r = vecs[v].valid;
         done_r  = vecs[v].done;
         do_reset(2);
         tick(0, 0);
         chk($sformatf("vec%0d_start", v), int'(bus.req_start), int'(vecs[v].exp_start));
         if (vecs[v].exp_start) chk($sformatf("vec%0d_pos", v), int'(bus.req_pos), vecs[v].exp_pos);
      end

`ifdef LISNOC_DMA_SCHED_TIMEOUT_EN
      // Timeout with no completion, then completion arriving in the last WAIT cycle.
      valid_r = 4'b0001;
      done_r  = 4'b0000;
      do_reset(2);
      tick(0, 0);
      tick(1, 0);
      for (int k = 1; k <= TO_CYC; k++) begin
         tick(0, 0);
         chk($sformatf("to_cycle%0d", k), int'(to_seen), int'(k == TO_CYC));
      end
      chk("to_done_set", int'(bus.done_set), 1);
      chk("to_done_pos", int'(bus.done_pos), 0);
      valid_r = 4'b0001;
      done_r  = 4'b0000;
      do_reset(2);
      tick(0, 0);
      tick(1, 0);
      for (int k = 1; k < TO_CYC; k++) tick(0, 0);
      tick(0, 1);
      chk("to_cmpl_wins", int'(to_seen), 0);
      chk("to_cmpl_done_set", int'(bus.done_set), 1);
`endif

      // Random table and initiator activity against the model, with one reset mid-run.
      valid_r = 4'b1111;
      done_r  = 4'b0000;
      do_reset(2);
      for (int cyc = 0; cyc < 4000; cyc++) begin
         bit a, c;
         if (cyc == 2000) do_reset(1);
         if ($urandom_range(5) == 0) valid_r[$urandom_range(N - 1)] ^= 1'b1;
         if ($urandom_range(4) == 0) done_r[$urandom_range(N - 1)] = 1'b0;
         a = bus.req_start ? ($urandom_range(2) == 0) : ($urandom_range(7) == 0);
         c = ($urandom_range(3) == 0);
         tick(a, c);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/lisnoc_dma_request_scheduler.md
Name: lisnoc_dma_request_scheduler

Overview:
Sequences the DMA request table. Scans entries that are valid and not done, picks one per transfer in round-robin order, and hands it to the DMA initiator with a start/ack handshake. On completion it marks the entry done. It sits between the request table (written over wishbone) and the initiator datapath.

Parameters:
table_entries, 4, number of request table entries. The pointer width is a localparam fixed at 2, so table_entries must be <= 4.
tileid, 0, local tile id, passed through to the trace only.

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-low (0 = reset)
valid  input  table_entries  per-entry valid bit from the request table
done  input  table_entries  per-entry done bit from the request table
req_pos  output  2  index of the entry being issued or executed
req_start  output  1  request to initiator; held high until req_ack
req_ack  input  1  initiator accepted req_pos
req_cmpl  input  1  initiator finished the current transfer; single-cycle pulse
done_set  output  1  one-cycle pulse: set done[done_pos]
done_pos  output  2  entry to mark done
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset values (sampled on a clk edge with rst=0): state=IDLE, rr_last=table_entries-1, req_pos=0, req_start=0, done_set=0, done_pos=0, busy=0.
- eligible = valid & ~done, evaluated combinationally.
- Round-robin rule: search starts at rr_last+1 and wraps modulo table_entries. The first set eligible bit wins.
- State IDLE:
  - If eligible != 0: register the winner into req_pos, go to ISSUE.
  - Otherwise stay in IDLE.
  - Latency: eligible seen at edge n gives req_start=1 after edge n+1.
- State ISSUE:
  - req_start=1 and req_pos stable.
  - req_ack=1 with req_cmpl=0: go to WAIT; rr_last<=req_pos.
  - req_ack=1 with req_cmpl=1 in the same cycle: go to FINISH; rr_last<=req_pos.
  - valid[req_pos]=0 with req_ack=0 (entry withdrawn): go to IDLE. No done_set; rr_last unchanged.
  - If valid drops and req_ack=1 in the same cycle, the ack wins.
- State WAIT:
  - req_start=0.
  - req_cmpl=1: go to FINISH.
  - Changes to valid or done in WAIT are ignored; the transfer always completes.
- State FINISH:
  - done_set=1 and done_pos=req_pos for exactly one cycle.
  - Go to IDLE.
  - The next grant is no earlier than 2 cycles after FINISH, so the table's done update is visible before the next scan.
- req_cmpl outside WAIT or ISSUE is ignored. req_ack outside ISSUE is ignored.
- Only one transfer is outstanding at a time.
- Reset mid-operation drops any transfer in flight and emits no done_set. Recovering the initiator is the system's responsibility.
- Fairness: an entry that stays eligible is granted within table_entries grants.

Optional Feature:
Macro: LISNOC_DMA_SCHED_TIMEOUT_EN.
- Defined:
  - Adds parameter timeout_cycles, default 1024.
  - Adds output port sched_timeout, 1 bit, reset value 0.
  - A counter runs in WAIT and clears on entering WAIT.
  - If it reaches timeout_cycles with no req_cmpl: sched_timeout pulses for one cycle and the state goes to FINISH. done_set still pulses, so the entry is released.
  - If req_cmpl arrives in the same cycle as the timeout, req_cmpl wins and sched_timeout stays 0.
- Undefined: no counter and no port; WAIT is unbounded.

Test Plan:
- Reset: hold rst=0 for 3 cycles with valid=4'b1111 -> req_start=0, busy=0, done_set=0 throughout. After release, req_pos=0 and req_start=1 one cycle later.
- Round-robin: valid=4'b1111, done=0. Ack each grant after 1 cycle and complete after 2 cycles, and let the bench set done on done_set -> grant order 0,1,2,3. Then none, since all entries are done.
- Skip and wrap: rr_last=2, valid=4'b1010 -> grant order 3 then 1.
- Withdraw: entry 2 in ISSUE; drop valid[2] before ack -> back to IDLE, no done_set. Re-validating entry 2 gives it the next grant.
- Same-cycle ack and completion on entry 1 -> FINISH on the next cycle; done_set=1, done_pos=1 for exactly 1 cycle.
- Timeout (macro defined, timeout_cycles=8): ack without ever sending req_cmpl -> sched_timeout=1 in the 8th WAIT cycle, followed by a done_set pulse. Repeat with req_cmpl in the 8th cycle -> sched_timeout stays 0.
